button_trigger: RTL and testbench

BUTTON_TRIGGER -- requirements
Module: button_trigger

---
 rtl/button_trigger.sv | 132 +++++++++++++
 tb/tb_button_trigger.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_trigger.sv
// rtl/button_trigger.sv - debounced push-button to one-shot animation trigger with holdoff and one-deep queue
module button_trigger #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    output logic       active,
    output logic       busy,
    output logic       pending,
    output logic [3:0] drop_cnt
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        HOLD = 2'd2
    } state_t;

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_d;
    logic          deb_dly_q;
    logic [DW-1:0] deb_cnt_q;
    logic [DW-1:0] deb_cnt_d;
    state_t        state_q;
    state_t        state_d;
    logic [HW-1:0] hold_cnt_q;
    logic [HW-1:0] hold_cnt_d;
    logic          pending_q;
    logic          pending_d;
    logic [3:0]    drop_q;
    logic [3:0]    drop_d;
    logic          press;

    // Two-flop synchronizer for the raw button level, plus one-cycle delay of the debounced level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_dly_q <= 1'b0;
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            deb_dly_q <= deb_q;
        end
    end

    // Debounce: count consecutive disagreeing cycles; flip the accepted level when the run is long enough.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = ~deb_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Debounce and trigger-control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_q      <= 1'b0;
            deb_cnt_q  <= '0;
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            pending_q  <= 1'b0;
            drop_q     <= 4'd0;
        end else begin
            deb_q      <= deb_d;
            deb_cnt_q  <= deb_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
        end
    end

    // Only a debounced rising level counts as a press; releases are ignored.
    assign press = deb_q & ~deb_dly_q;

    // Trigger FSM: fire once, hold off for the animation, queue one press and count the rest as dropped.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        pending_d  = pending_q;
        drop_d     = drop_q;
        case (state_q)
            IDLE: begin
                if (press || pending_q) begin
                    state_d = FIRE;
                    // Issuing the queued press empties the queue unless a fresh press arrives together with it.
                    pending_d = pending_q & press;
                end
            end
            FIRE: begin
                state_d    = HOLD;
                hold_cnt_d = HW'(HOLDOFF_CYCLES - 1);
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_q != IDLE && press) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else if (drop_q != 4'hF) begin
                drop_d = drop_q + 4'd1;
            end
        end
    end

    assign active   = (state_q == FIRE);
    assign busy     = (state_q != IDLE);
    assign pending  = pending_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_button_trigger.sv
// tb/tb_button_trigger.sv - self-checking bench for button_trigger
module tb_button_trigger;

    localparam int DEB  = 4;
    localparam int HOLD = 50;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn   = 1'b0;
    logic       active;
    logic       busy;
    logic       pending;
    logic [3:0] drop_cnt;

    int checks   = 0;
    int failures = 0;
    int ecount   = 0;

    // Reference model state: trigger timeline by absolute cycle number.
    int m_cyc  = 0;
    int m_lf   = -1000;
    int m_run  = 0;
    int m_drop = 0;
    bit m_s1, m_s2, m_deb, m_debp, m_pend;

    button_trigger #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk     (clk),
        .reset   (rst_n),
        .btn     (btn),
        .active  (active),
        .busy    (busy),
        .pending (pending),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit lvl;
        int n;
        int pulses;
        bit exp_busy;
        bit exp_pend;
        int exp_drop;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_debp = 0; m_pend = 0;
        m_run = 0; m_drop = 0; m_cyc = 0; m_lf = -1000;
    endtask

    task automatic model_step();
        bit press;
        bit idle;
        press = m_deb && !m_debp;
        idle  = !(m_cyc >= m_lf && m_cyc <= m_lf + HOLD);
        if (idle && (press || m_pend)) begin
            m_lf   = m_cyc + 1;
            m_pend = m_pend && press;
        end else if (!idle && press) begin
            if (m_pend) m_drop = (m_drop >= 15) ? 15 : m_drop + 1;
            else        m_pend = 1;
        end
        m_debp = m_deb;
        if (m_s2 != m_deb) begin
            m_run++;
            if (m_run == DEB) begin
                m_deb = !m_deb;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = btn;
        m_cyc++;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
    end

    initial forever begin
        @(posedge clk);
        ecount++;
    end

    // Continuous comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("m_active",  active,   32'(m_cyc == m_lf));
        check("m_busy",    busy,     32'(m_cyc >= m_lf && m_cyc <= m_lf + HOLD));
        check("m_pending", pending,  32'(m_pend));
        check("m_drop",    drop_cnt, 32'(m_drop));
    end

    task automatic run_edges(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (active) pulses++;
        end
    endtask

    task automatic wait_active(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(posedge clk); #1;
            if (active) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        check("rst_active",  active,   0);
        check("rst_busy",    busy,     0);
        check("rst_pending", pending,  0);
        check("rst_drop",    drop_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    vec_t tbl [11];
    int   p;
    int   n;
    int   t1;
    int   t2;

    initial begin
        tbl = '{
            '{1'b1,  3, 0, 1'b0, 1'b0, 0},
            '{1'b0, 10, 0, 1'b0, 1'b0, 0},
            '{1'b1, 20, 1, 1'b1, 1'b0, 0},
            '{1'b0, 60, 0, 1'b0, 1'b0, 0},
            '{1'b1,  8, 1, 1'b1, 1'b0, 0},
            '{1'b0, 12, 0, 1'b1, 1'b0, 0},
            '{1'b1,  8, 0, 1'b1, 1'b1, 0},
            '{1'b0, 12, 0, 1'b1, 1'b1, 0},
            '{1'b1,  8, 0, 1'b1, 1'b1, 1},
            '{1'b0, 20, 1, 1'b1, 1'b0, 1},
            '{1'b0, 60, 0, 1'b0, 1'b0, 1}
        };

        rst_n = 0;
        btn   = 0;
        repeat (3) @(negedge clk);
        check("reset_active",  active,   0);
        check("reset_busy",    busy,     0);
        check("reset_pending", pending,  0);
        check("reset_drop",    drop_cnt, 0);
        @(posedge clk); #1 rst_n = 1;

        for (int i = 0; i < 11; i++) begin
            btn = tbl[i].lvl;
            run_edges(tbl[i].n, p);
            check($sformatf("vec%0d_pulses", i),  p,        tbl[i].pulses);
            check($sformatf("vec%0d_busy", i),    busy,     tbl[i].exp_busy);
            check($sformatf("vec%0d_pending", i), pending,  tbl[i].exp_pend);
            check($sformatf("vec%0d_drop", i),    drop_cnt, tbl[i].exp_drop);
        end

        // Clean press latency, then a queued press gives 52-cycle spacing.
        btn = 0;
        do_reset();
        repeat (5) @(posedge clk);
        #1 btn = 1;
        wait_active(20, n);
        check("press_latency", n, 7);
        t1 = ecount;
        repeat (3) @(posedge clk);
        #1 btn = 0;
        repeat (6) @(posedge clk);
        #1 btn = 1;
        repeat (8) @(posedge clk);
        #1 btn = 0;
        check("queued_pending", pending, 1);
        wait_active(100, n);
        check("second_found", 32'(n > 0), 1);
        t2 = ecount;
        check("trigger_spacing", t2 - t1, HOLD + 2);
        @(posedge clk); #1;
        check("pending_cleared", pending, 0);

        // Queue a press, then reset about 20 cycles into HOLD.
        repeat (4) @(posedge clk);
        #1 btn = 1;
        repeat (8) @(posedge clk);
        #1 btn = 0;
        repeat (6) @(posedge clk);
        check("pre_reset_pending", pending, 1);
        check("pre_reset_busy",    busy,    1);
        do_reset();
        run_edges(100, p);
        check("post_reset_pulses", p, 0);

        // Button held through reset release, then a long press and release.
        btn = 1;
        do_reset();
        wait_active(20, n);
        check("held_release_latency", n, 7);
        run_edges(200, p);
        check("long_press_extra", p, 0);
        #1 btn = 0;
        run_edges(60, p);
        check("release_pulses", p, 0);
        check("long_press_drop", drop_cnt, 0);

        // Continuous presses saturate the drop counter.
        do_reset();
        repeat (48) begin
            btn = 1;
            repeat (8) @(posedge clk);
            #1 btn = 0;
            repeat (8) @(posedge clk);
            #1;
        end
        check("drop_saturated", drop_cnt, 15);
        check("sat_pending", pending, 1);

        // Randomized segments with occasional resets, checked against the model.
        repeat (150) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            btn = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 14)) @(posedge clk);
            #1;
        end

        btn = 0;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
